// File: rtl/demux4_stream.sv
// 1-to-4 stream demultiplexer: one input stream routed by in_sel into four 2-entry channel FIFOs.
// Latency: an accepted beat shows on out_valid[k] one cycle later when channel k was empty.
// Backpressure: in_ready drops only when the selected channel holds 2 entries; other channels are unaffected.
module demux4_stream #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [1:0]     in_sel,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*W-1:0] out_data,
  output logic [3:0]     ch_full
);

  // Acceptance depends only on the registered fill level of the selected channel,
  // never on out_ready, so the producer sees no combinational path from consumers.
  assign in_ready = rst_n && !ch_full[in_sel];

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              rd_nxt;
    logic [1:0][W-1:0] mem;
    logic [W-1:0]      head;
    logic              push;
    logic              pop;

    assign push = in_valid && in_ready && (in_sel == 2'(k));
    assign pop  = (cnt != 2'd0) && out_ready[k];

    // Next fill level and read pointer for this channel.
    always_comb begin
      cnt_nxt = cnt;
      rd_nxt  = rd_ptr;
      if (push && !pop) cnt_nxt = cnt + 2'd1;
      if (pop && !push) cnt_nxt = cnt - 2'd1;
      if (pop)          rd_nxt  = ~rd_ptr;
    end

    // FIFO storage, pointers and a registered head copy. The head register only
    // reloads while the channel will be non-empty, so an emptied channel keeps
    // presenting the last beat it delivered rather than a stale storage slot.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        mem    <= '0;
        head   <= '0;
      end else begin
        cnt    <= cnt_nxt;
        rd_ptr <= rd_nxt;
        if (push) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= ~wr_ptr;
        end
        // The incoming beat becomes head when it lands in the slot the read
        // pointer will address next (empty push, or push+pop at count 1).
        if (cnt_nxt != 2'd0) begin
          if (push && (wr_ptr == rd_nxt)) head <= in_data;
          else                            head <= mem[rd_nxt];
        end
      end
    end

    assign out_valid[k]        = (cnt != 2'd0);
    assign ch_full[k]          = (cnt == 2'd2);
    assign out_data[k*W +: W]  = head;
  end

endmodule
